// File: rtl/c3lib_rst_seq_pkg.sv
// rtl/c3lib_rst_seq_pkg.sv - state encodings for the staged reset-release sequencer
package c3lib_rst_seq_pkg;

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_DELAY   = 2'd1;
    localparam logic [1:0] ST_ACKWAIT = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        HOLD    = ST_HOLD,
        DELAY   = ST_DELAY,
        ACKWAIT = ST_ACKWAIT,
        DONE    = ST_DONE
    } rst_seq_state_e;

endpackage

// File: rtl/c3lib_rst_sync.sv
// rtl/c3lib_rst_sync.sv - reset deassertion synchronizer, async clear, shifts in 1s
module c3lib_rst_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    output logic o_release_ok
);

    logic [SYNC_DEPTH-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign o_release_ok = r_chain[SYNC_DEPTH-1];

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// rtl/c3lib_rst_seq_ctrl.sv - staged reset-release sequencer with per-stage delay and ack timeout
module c3lib_rst_seq_ctrl
    import c3lib_rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int SYNC_DEPTH = 2,
    parameter int DLY_CYC    = 16,
    parameter int ACK_TO     = 64,
    parameter int CNT_W      = $clog2(((DLY_CYC > ACK_TO) ? DLY_CYC : ACK_TO) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic                  seq_err
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DLY_CYC - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TO - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    rst_seq_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic [NUM_STAGES-1:0] r_out, w_out_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_release_ok;
    logic                  w_advance;

    c3lib_rst_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
        .clk          (clk),
        .rst          (rst),
        .o_release_ok (w_release_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_out   <= w_out_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_out_nxt   = r_out;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_advance   = 1'b0;
        if (sw_rst_req) begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_out_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (w_release_ok) begin
                        w_state_nxt = DELAY;
                        w_cnt_nxt   = '0;
                    end
                end
                DELAY: begin
                    // The release edge is also the first ack sample, so an
                    // already-ready stage costs no extra cycle.
                    if (r_cnt == DLY_LAST) begin
                        w_out_nxt[r_idx] = 1'b1;
                        if (stage_ack[r_idx]) begin
                            w_advance = 1'b1;
                        end else begin
                            w_state_nxt = ACKWAIT;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ACKWAIT: begin
                    if (stage_ack[r_idx]) begin
                        w_advance = 1'b1;
                    end else if (r_cnt == ACK_LAST) begin
                        w_err_nxt = 1'b1;
                        w_advance = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_advance) begin
                if (r_idx == IDX_LAST) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = DELAY;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_cnt_nxt   = '0;
                end
            end
        end
    end

    assign rst_n_out = r_out;
    assign seq_done  = r_done;
    assign seq_err   = r_err;

endmodule

// File: tb/tb_c3lib_rst_seq_ctrl.sv
// tb/tb_c3lib_rst_seq_ctrl.sv - directed vector bench for the staged reset sequencer
module tb_c3lib_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic [3:0] stage_ack = 4'h0;
    logic [3:0] rst_n_out;
    logic       seq_done;
    logic       seq_err;

    int n_pass = 0;
    int n_total = 0;
    int edge_n = 0;

    typedef struct {
        bit         do_rst;
        int         at_edge;
        logic       sw;
        logic [3:0] ack;
        logic [3:0] out;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    c3lib_rst_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sw_rst_req (sw_rst_req),
        .stage_ack  (stage_ack),
        .rst_n_out  (rst_n_out),
        .seq_done   (seq_done),
        .seq_err    (seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_n, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic is_thermo(input logic [3:0] v);
        logic [4:0] w;
        w = {1'b0, v} + 5'd1;
        return (w[3:0] & v) == 4'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        check("thermometer", {31'd0, is_thermo(rst_n_out)}, 32'd1);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] out, input logic done, input logic err);
        check({tag, ".rst_n_out"}, {28'd0, rst_n_out}, {28'd0, out});
        check({tag, ".seq_done"}, {31'd0, seq_done}, {31'd0, done});
        check({tag, ".seq_err"}, {31'd0, seq_err}, {31'd0, err});
    endtask

    task automatic restart();
        rst = 1'b1;
        sw_rst_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        edge_n = 0;
    endtask

    function automatic vec_t mk(input bit r, input int e, input logic s, input logic [3:0] a,
                                input logic [3:0] o, input logic d, input logic er);
        vec_t v;
        v.do_rst = r; v.at_edge = e; v.sw = s; v.ack = a;
        v.out = o; v.done = d; v.err = er;
        return v;
    endfunction

    initial begin
        // all acks ready: one stage per DLY_CYC edges, done with the last release
        vecs.push_back(mk(1,   1, 0, 4'hF, 4'b0000, 0, 0));
        vecs.push_back(mk(0,  18, 0, 4'hF, 4'b0000, 0, 0));
        vecs.push_back(mk(0,  19, 0, 4'hF, 4'b0001, 0, 0));
        vecs.push_back(mk(0,  34, 0, 4'hF, 4'b0001, 0, 0));
        vecs.push_back(mk(0,  35, 0, 4'hF, 4'b0011, 0, 0));
        vecs.push_back(mk(0,  50, 0, 4'hF, 4'b0011, 0, 0));
        vecs.push_back(mk(0,  51, 0, 4'hF, 4'b0111, 0, 0));
        vecs.push_back(mk(0,  66, 0, 4'hF, 4'b0111, 0, 0));
        vecs.push_back(mk(0,  67, 0, 4'hF, 4'b1111, 1, 0));
        vecs.push_back(mk(0,  80, 0, 4'hF, 4'b1111, 1, 0));
        // stage 1 never acks: timeout after 64 ACKWAIT edges
        vecs.push_back(mk(1,  19, 0, 4'hD, 4'b0001, 0, 0));
        vecs.push_back(mk(0,  35, 0, 4'hD, 4'b0011, 0, 0));
        vecs.push_back(mk(0,  98, 0, 4'hD, 4'b0011, 0, 0));
        vecs.push_back(mk(0,  99, 0, 4'hD, 4'b0011, 0, 1));
        vecs.push_back(mk(0, 114, 0, 4'hD, 4'b0011, 0, 1));
        vecs.push_back(mk(0, 115, 0, 4'hD, 4'b0111, 0, 1));
        vecs.push_back(mk(0, 130, 0, 4'hD, 4'b0111, 0, 1));
        vecs.push_back(mk(0, 131, 0, 4'hD, 4'b1111, 1, 1));
        vecs.push_back(mk(0, 140, 0, 4'hD, 4'b1111, 1, 1));
        // soft reset from DONE for 3 edges, then restart
        vecs.push_back(mk(0, 141, 1, 4'hD, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 143, 1, 4'hD, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 159, 0, 4'hF, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 160, 0, 4'hF, 4'b0001, 0, 0));
        vecs.push_back(mk(0, 176, 0, 4'hF, 4'b0011, 0, 0));

        #2;
        check_outs("reset", 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) restart();
            while (edge_n < vecs[i].at_edge) begin
                sw_rst_req = vecs[i].sw;
                stage_ack  = vecs[i].ack;
                tick();
            end
            check_outs($sformatf("vec%0d", i), vecs[i].out, vecs[i].done, vecs[i].err);
        end

        // async reset mid-DELAY of stage 2, no clock edge needed
        stage_ack = 4'hF;
        restart();
        while (edge_n < 40) tick();
        check_outs("pre_async", 4'b0011, 0, 0);
        rst = 1'b1;
        #1;
        check_outs("async_rst", 4'b0000, 0, 0);
        #1;
        rst = 1'b0;
        edge_n = 0;
        while (edge_n < 18) tick();
        check_outs("async_e18", 4'b0000, 0, 0);
        tick();
        check_outs("async_e19", 4'b0001, 0, 0);

        // soft reset and ack on the same ACKWAIT edge: soft reset wins
        stage_ack = 4'hE;
        restart();
        while (edge_n < 25) tick();
        check_outs("ackwait0", 4'b0001, 0, 0);
        sw_rst_req = 1'b1;
        stage_ack  = 4'hF;
        tick();
        check_outs("sw_vs_ack", 4'b0000, 0, 0);
        sw_rst_req = 1'b0;
        while (edge_n < 42) tick();
        check_outs("sw_e42", 4'b0000, 0, 0);
        tick();
        check_outs("sw_e43", 4'b0001, 0, 0);
        while (edge_n < 59) tick();
        check_outs("sw_e59", 4'b0011, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
